// File: rtl/uart_rx_pkg.sv
// ============================================================================
// Package     : uart_rx_pkg
// Description : Shared types and helpers for the parametrised UART-Rx SIPO
//               stage: receiver state encoding, parity-mode constants and the
//               frame-width calculation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_rx_pkg;

  // Receiver phases, in the order a frame passes through them
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  // Values of parity_odd
  localparam logic c_PARITY_EVEN = 1'b0;
  localparam logic c_PARITY_ODD  = 1'b1;

  // Total bits on the line for one frame, start bit included
  function automatic int frame_width(input int data_bits,
                                     input int parity_en,
                                     input int stop_bits);
    return 1 + data_bits + parity_en + stop_bits;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rx_majority_sampler.sv
// ============================================================================
// Module      : rx_majority_sampler
// Description : Three-sample majority voter. The two earlier samples of a bit
//               window are held in a short shift register; the third sample
//               is the live line value on the vote edge, so the vote is
//               available combinationally on the edge it resolves.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_majority_sampler (
  input  logic baud_clk,
  input  logic reset_n,
  input  logic sample_en,
  input  logic data_in,
  output logic vote
);

  logic [1:0] r_hist;

  // Shift in the line on each sampling tick; idle-high reset value
  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hist <= 2'b11;
    end else if (sample_en) begin
      r_hist <= {r_hist[0], data_in};
    end
  end

  assign vote = (r_hist[1] & r_hist[0]) |
                (r_hist[1] & data_in)   |
                (r_hist[0] & data_in);

endmodule

`default_nettype wire

// File: rtl/uart_rx_sipo_param.sv
// ============================================================================
// Module      : uart_rx_sipo_param
// Description : Parametrised UART receiver, serial-in parallel-out. Samples
//               the line on the oversampling clock, votes over three samples
//               per bit and assembles start/data/parity/stop bits into a
//               parallel frame with error flags and a one-cycle completion
//               pulse. Completion happens mid stop bit so back-to-back frames
//               need no idle gap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_sipo_param
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int FRAME_W    = frame_width(DATA_BITS, PARITY_EN, STOP_BITS)
) (
  input  logic                 baud_clk,
  input  logic                 reset_n,
  input  logic                 data_tx,
  input  logic                 parity_odd,
  output logic                 active_flag,
  output logic                 received_flag,
  output logic [FRAME_W-1:0]   data_parll,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 parity_error,
  output logic                 stop_error,
  output logic                 start_glitch
);

  localparam int c_TICK_W = $clog2(OVERSAMPLE);
  localparam int c_IDX_W  = $clog2(FRAME_W);
  localparam int c_HALF   = OVERSAMPLE / 2;

  localparam logic [c_TICK_W-1:0] c_TICK_ONE   = c_TICK_W'(1);
  localparam logic [c_TICK_W-1:0] c_TICK_FIRST = c_TICK_W'(c_HALF - 1);
  localparam logic [c_TICK_W-1:0] c_TICK_MID   = c_TICK_W'(c_HALF);
  localparam logic [c_TICK_W-1:0] c_TICK_VOTE  = c_TICK_W'(c_HALF + 1);

  localparam logic [c_IDX_W-1:0]  c_IDX_ONE       = c_IDX_W'(1);
  localparam logic [c_IDX_W-1:0]  c_IDX_LAST_DATA = c_IDX_W'(DATA_BITS);
  localparam logic [c_IDX_W-1:0]  c_IDX_LAST      = c_IDX_W'(FRAME_W - 1);

  rx_state_t              r_state;
  rx_state_t              w_state_nxt;
  logic [c_TICK_W-1:0]    r_tick;
  logic [c_IDX_W-1:0]     r_idx;
  logic                   r_par_odd;
  logic [FRAME_W-2:0]     r_frame;
  logic                   r_received;
  logic                   r_glitch;
  logic [FRAME_W-1:0]     r_parll;
  logic [DATA_BITS-1:0]   r_dout;
  logic                   r_perr;
  logic                   r_serr;

  logic                   w_sample_en;
  logic                   w_vote;
  logic                   w_vote_edge;
  logic                   w_start;
  logic                   w_done;
  logic                   w_glitch;
  logic [FRAME_W-1:0]     w_frame_full;
  logic                   w_par_err;
  logic                   w_stop_err;

  // Samples are taken on the three ticks centred on mid-bit
  assign w_sample_en = (r_state != IDLE) &&
                       ((r_tick == c_TICK_FIRST) ||
                        (r_tick == c_TICK_MID)   ||
                        (r_tick == c_TICK_VOTE));
  assign w_vote_edge = (r_state != IDLE) && (r_tick == c_TICK_VOTE);

  rx_majority_sampler u_sampler (
    .baud_clk  (baud_clk),
    .reset_n   (reset_n),
    .sample_en (w_sample_en),
    .data_in   (data_tx),
    .vote      (w_vote)
  );

  // State register
  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and frame-event decode
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_done      = 1'b0;
    w_glitch    = 1'b0;
    case (r_state)
      IDLE: begin
        if (!data_tx) begin
          w_start     = 1'b1;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_vote_edge) begin
          if (w_vote) begin
            w_glitch    = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (w_vote_edge && (r_idx == c_IDX_LAST_DATA)) begin
          w_state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (w_vote_edge) begin
          w_state_nxt = STOP;
        end
      end
      STOP: begin
        // Finish on the last stop vote, mid bit, so IDLE can catch the next start
        if (w_vote_edge && (r_idx == c_IDX_LAST)) begin
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Tick and bit-index counters; the start-detect edge is tick 0
  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tick    <= '0;
      r_idx     <= '0;
      r_par_odd <= c_PARITY_EVEN;
    end else if (w_start) begin
      r_tick    <= c_TICK_ONE;
      r_idx     <= '0;
      r_par_odd <= parity_odd;
    end else if (w_done || w_glitch || (r_state == IDLE)) begin
      r_tick <= '0;
      r_idx  <= '0;
    end else begin
      r_tick <= r_tick + c_TICK_ONE;
      if (w_vote_edge) begin
        r_idx <= r_idx + c_IDX_ONE;
      end
    end
  end

  // Frame assembly: voted bits enter at the top, so bit 0 ends up at the bottom
  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame <= '1;
    end else if (w_vote_edge) begin
      r_frame <= {w_vote, r_frame[FRAME_W-2:1]};
    end
  end

  // The final stop vote completes the frame in the same edge
  assign w_frame_full = {w_vote, r_frame};
  assign w_stop_err   = ~&w_frame_full[FRAME_W-1 -: STOP_BITS];

  generate
    if (PARITY_EN != 0) begin : g_parity
      // Expected bit is the data XOR-reduction, inverted for odd mode
      assign w_par_err = (^w_frame_full[DATA_BITS:1]) ^ r_par_odd ^
                         w_frame_full[DATA_BITS+1];
    end else begin : g_no_parity
      assign w_par_err = 1'b0;
    end
  endgenerate

  // Result registers: pulses every cycle, payload and flags only on completion
  always_ff @(posedge baud_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_received <= 1'b0;
      r_glitch   <= 1'b0;
      r_parll    <= '1;
      r_dout     <= '0;
      r_perr     <= 1'b0;
      r_serr     <= 1'b0;
    end else begin
      r_received <= w_done;
      r_glitch   <= w_glitch;
      if (w_done) begin
        r_parll <= w_frame_full;
        r_dout  <= w_frame_full[DATA_BITS:1];
        r_perr  <= w_par_err;
        r_serr  <= w_stop_err;
      end
    end
  end

  assign active_flag   = (r_state != IDLE);
  assign received_flag = r_received;
  assign start_glitch  = r_glitch;
  assign data_parll    = r_parll;
  assign data_out      = r_dout;
  assign parity_error  = r_perr;
  assign stop_error    = r_serr;

endmodule

`default_nettype wire
